// File: rtl/countdown_timer.sv
// Countdown timer: a down-counter stepped by a programmable-rate tick strobe.
// Latency: CounterValue updates on the edge that ends a Tick cycle; Tick and Done are combinational.
// Backpressure: none; Enable low freezes the divider and the count, Load overrides Enable.
//
// Ports:
//   Clock        rising-edge clock for all state
//   Clear_b      synchronous active-low reset (count -> 0, divider -> P-1)
//   Enable       run; low holds the divider and the count
//   Load         load LoadValue into the count and restart the divider period
//   LoadValue    8-bit unsigned start value
//   Speed        tick-rate select: 00 -> P=1, 01 -> P=CLOCK_HZ, 10 -> 2*CLOCK_HZ, 11 -> 4*CLOCK_HZ
//   CounterValue registered current count
//   Tick         one-cycle pulse every P enabled cycles (free-running, also at count 0)
//   Done         high while CounterValue == 0
module countdown_timer #(
  parameter int CLOCK_HZ = 50_000_000
) (
  input  logic       Clock,
  input  logic       Clear_b,
  input  logic       Enable,
  input  logic       Load,
  input  logic [7:0] LoadValue,
  input  logic [1:0] Speed,
  output logic [7:0] CounterValue,
  output logic       Tick,
  output logic       Done
);

  // Divider wide enough to hold 4*CLOCK_HZ-1, never narrower than one bit.
  localparam int DW = ($clog2(4 * CLOCK_HZ) > 0) ? $clog2(4 * CLOCK_HZ) : 1;

  localparam logic [DW-1:0] PM1_X1 = DW'(CLOCK_HZ - 1);
  localparam logic [DW-1:0] PM1_X2 = DW'(2 * CLOCK_HZ - 1);
  localparam logic [DW-1:0] PM1_X4 = DW'(4 * CLOCK_HZ - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] period_m1;
  logic          div_zero;

  // Reload value P-1 taken from Speed at the reloading edge, so a Speed change
  // only affects the period that starts after the current one finishes.
  always_comb begin
    period_m1 = '0;
    unique case (Speed)
      2'b00:   period_m1 = '0;
      2'b01:   period_m1 = PM1_X1;
      2'b10:   period_m1 = PM1_X2;
      default: period_m1 = PM1_X4;
    endcase
  end

  assign div_zero = (div_q == '0);

  // Load and reset both suppress Tick so a coinciding load never also decrements.
  assign Tick = Enable & ~Load & Clear_b & div_zero;
  assign Done = (CounterValue == 8'd0);

  always_ff @(posedge Clock) begin
    if (!Clear_b) begin
      CounterValue <= 8'd0;
      div_q        <= period_m1;
    end else if (Load) begin
      CounterValue <= LoadValue;
      div_q        <= period_m1;
    end else if (Enable) begin
      if (div_zero) begin
        div_q <= period_m1;
        // Saturate at zero; Tick keeps running as a strobe.
        if (CounterValue != 8'd0) begin
          CounterValue <= CounterValue - 8'd1;
        end
      end else begin
        div_q <= div_q - DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with CLOCK_HZ=4 (P = 1, 4, 8, 16).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_countdown_timer;

  localparam int CLOCK_HZ = 4;

  logic       Clock = 1'b0;
  logic       Clear_b;
  logic       Enable;
  logic       Load;
  logic [7:0] LoadValue;
  logic [1:0] Speed;
  logic [7:0] CounterValue;
  logic       Tick;
  logic       Done;

  always #5 Clock = ~Clock;

  countdown_timer #(.CLOCK_HZ(CLOCK_HZ)) dut (
    .Clock        (Clock),
    .Clear_b      (Clear_b),
    .Enable       (Enable),
    .Load         (Load),
    .LoadValue    (LoadValue),
    .Speed        (Speed),
    .CounterValue (CounterValue),
    .Tick         (Tick),
    .Done         (Done)
  );

  typedef struct packed {
    logic [7:0] cv;
    logic       tick;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic drive(input logic clr, input logic en, input logic ld,
                       input logic [7:0] lv, input logic [1:0] sp);
    Clear_b   = clr;
    Enable    = en;
    Load      = ld;
    LoadValue = lv;
    Speed     = sp;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] cv, input logic tick);
    exp_t e;
    e.cv   = cv;
    e.tick = tick;
    e.done = (cv == 8'd0);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (CounterValue === e.cv) else begin
      errors++;
      $error("FAIL %s CounterValue got %0d want %0d", t, CounterValue, e.cv);
    end
    checks++;
    assert (Tick === e.tick) else begin
      errors++;
      $error("FAIL %s Tick got %b want %b", t, Tick, e.tick);
    end
    checks++;
    assert (Done === e.done) else begin
      errors++;
      $error("FAIL %s Done got %b want %b", t, Done, e.done);
    end
  endtask

  // One clock: wait for the edge, drive this cycle's inputs, record the
  // expected outputs for this cycle, then compare once they have settled.
  task automatic cyc(input logic clr, input logic en, input logic ld,
                     input logic [7:0] lv, input logic [1:0] sp,
                     input string tag, input logic [7:0] e_cv, input logic e_tick);
    @(posedge Clock);
    #1;
    drive(clr, en, ld, lv, sp);
    push_exp(tag, e_cv, e_tick);
    #1;
    check_pop();
  endtask

  logic [7:0] s2_cv [6];
  logic [7:0] cv_e;
  logic       en_e;
  logic [1:0] sp_e;

  initial begin
    s2_cv = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};

    // Reset held two cycles with Load active: load must be ignored.
    drive(1'b0, 1'b1, 1'b1, 8'hAA, 2'b00);
    cyc(1'b0, 1'b1, 1'b1, 8'hAA, 2'b00, "rst0", 8'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'hAA, 2'b00, "rst1", 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h05, 2'b00, "rst_rel", 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, "ld5", 8'd5, 1'b0);

    // Speed 00: tick every cycle, count saturates at 0.
    cyc(1'b1, 1'b0, 1'b1, 8'd3, 2'b00, "s00_ld", 8'd5, 1'b0);
    for (int j = 0; j < 6; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 2'b00, "s00_run", s2_cv[j], 1'b1);
    end

    // Speed 01 (P=4): ticks end on edges 4, 8, 12 after the load edge.
    cyc(1'b1, 1'b1, 1'b1, 8'd2, 2'b01, "s01_ld", 8'd0, 1'b0);
    for (int j = 0; j <= 12; j++) begin
      cv_e = (j < 4) ? 8'd2 : (j < 8) ? 8'd1 : 8'd0;
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 2'b01, "s01_run", cv_e, (j % 4) == 3);
    end

    // Speed 11 (P=16): 6 enabled, 10 frozen, resume from frozen divider.
    cyc(1'b1, 1'b0, 1'b1, 8'd50, 2'b11, "s11_ld", 8'd0, 1'b0);
    for (int j = 0; j <= 26; j++) begin
      en_e = (j < 6) || (j >= 16);
      cv_e = (j <= 25) ? 8'd50 : 8'd49;
      cyc(1'b1, en_e, 1'b0, 8'd0, 2'b11, "s11_pause", cv_e, j == 25);
    end

    // Load in the cycle where the divider reaches zero: load wins, no tick.
    cyc(1'b1, 1'b1, 1'b1, 8'd20, 2'b01, "coll_ld", 8'd49, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 2'b01, "coll_pre", 8'd20, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b1, 8'd9, 2'b01, "coll_hit", 8'd20, 1'b0);
    for (int j = 0; j <= 4; j++) begin
      cv_e = (j < 4) ? 8'd9 : 8'd8;
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 2'b01, "coll_post", cv_e, j == 3);
    end

    // Speed 01 -> 10 mid-period: current period stays 4, next one is 8.
    cyc(1'b1, 1'b1, 1'b1, 8'd100, 2'b01, "spd_ld", 8'd8, 1'b0);
    for (int j = 0; j <= 12; j++) begin
      sp_e = (j >= 1) ? 2'b10 : 2'b01;
      cv_e = (j < 4) ? 8'd100 : (j < 12) ? 8'd99 : 8'd98;
      cyc(1'b1, 1'b1, 1'b0, 8'd0, sp_e, "spd_chg", cv_e, (j == 3) || (j == 11));
    end

    // Reset mid-countdown overrides Load/Enable; tick keeps running at count 0.
    cyc(1'b0, 1'b1, 1'b1, 8'd77, 2'b01, "clr_mid", 8'd98, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 2'b01, "clr_hold", 8'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 2'b01, "clr_rel", 8'd0, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'd0, 2'b01, "zero_strobe", 8'd0, j == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
